// File: rtl/debounce_pkg.sv
// Shared limits and helpers for the pushbutton debouncer.
package debounce_pkg;

    localparam int MIN_WIDTH     = 2;
    localparam int MAX_WIDTH     = 16;
    localparam int MIN_LOG2DELAY = 1;
    localparam int MAX_LOG2DELAY = 24;

    // Width of a channel index; never below one bit.
    function automatic int chan_bits(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced input: 2-flop synchronizer, stability counter, stable level and edge strobes.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int LOG2DELAY = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_o,
    output logic rise_o,
    output logic fall_o,
    output logic chg_o
);

    localparam logic [LOG2DELAY-1:0] CNT_MAX = '1;

    if (LOG2DELAY < MIN_LOG2DELAY || LOG2DELAY > MAX_LOG2DELAY) begin : g_bad_delay
        $error("debounce_chan: LOG2DELAY out of range");
    end

    logic                 s1_q;
    logic                 s2_q;
    logic                 btn_q;
    logic                 btn_d;
    logic                 rise_q;
    logic                 fall_q;
    logic [LOG2DELAY-1:0] cnt_q;
    logic [LOG2DELAY-1:0] cnt_d;

    // The level only moves after the synchronized input disagrees for a full window.
    always_comb begin
        cnt_d = cnt_q;
        btn_d = btn_q;
        if (s2_q == btn_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            btn_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign chg_o = (btn_d != btn_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            btn_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            btn_q  <= btn_d;
            cnt_q  <= cnt_d;
            rise_q <= chg_o & btn_d;
            fall_q <= chg_o & ~btn_d;
        end
    end

    assign btn_o  = btn_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH pad inputs and reports clean levels, edge strobes and a valid/ready event stream.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LOG2DELAY = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              btn_i,
    output logic [WIDTH-1:0]              btn_o,
    output logic [WIDTH-1:0]              rise_o,
    output logic [WIDTH-1:0]              fall_o,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [chan_bits(WIDTH)-1:0]   evt_chan,
    output logic                          evt_rise,
    output logic                          ovf_o
);

    localparam int CW = chan_bits(WIDTH);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("button_debouncer: WIDTH out of range");
    end

    // Handshake: an event transfers on a rising edge where evt_valid && evt_ready;
    // while evt_valid is high and evt_ready low, evt_chan and evt_rise are held.
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pend_d;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] dir_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             evt_valid_q;
    logic [CW-1:0]    evt_chan_q;
    logic             evt_rise_q;
    logic             load;
    logic             found;
    logic [CW-1:0]    sel;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_chan #(
            .LOG2DELAY(LOG2DELAY)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (btn_i[g]),
            .btn_o (btn_o[g]),
            .rise_o(rise_o[g]),
            .fall_o(fall_o[g]),
            .chg_o (chg[g])
        );
    end

    assign load = !evt_valid_q || evt_ready;

    // Lowest pending channel index wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                found = 1'b1;
                sel   = CW'(i);
            end
        end
    end

    // A fresh edge re-arms pend after any transfer; it overflows only if the old one is still waiting.
    always_comb begin
        pend_d = pend_q;
        dir_d  = dir_q;
        ovf_d  = ovf_q;
        if (load && found) begin
            pend_d[sel] = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (chg[i]) begin
                if (pend_d[i]) begin
                    ovf_d = 1'b1;
                end
                pend_d[i] = 1'b1;
                dir_d[i]  = ~btn_o[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= '0;
            dir_q       <= '0;
            ovf_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_chan_q  <= '0;
            evt_rise_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            dir_q  <= dir_d;
            ovf_q  <= ovf_d;
            if (load) begin
                if (found) begin
                    evt_valid_q <= 1'b1;
                    evt_chan_q  <= sel;
                    evt_rise_q  <= dir_q[sel];
                end else begin
                    evt_valid_q <= 1'b0;
                end
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_chan  = evt_chan_q;
    assign evt_rise  = evt_rise_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random presses against a cycle reference model.
module tb_button_debouncer;

  localparam int WIDTH     = 4;
  localparam int LOG2DELAY = 3;
  localparam int CW        = 2;
  localparam int W         = CW + 1;
  localparam int WINDOW    = 1 << LOG2DELAY;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] btn_i;
  logic [WIDTH-1:0] btn_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             evt_valid;
  logic             evt_ready;
  logic [CW-1:0]    evt_chan;
  logic             evt_rise;
  logic             ovf_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  button_debouncer #(
    .WIDTH    (WIDTH),
    .LOG2DELAY(LOG2DELAY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (btn_i),
    .btn_o    (btn_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_chan (evt_chan),
    .evt_rise (evt_rise),
    .ovf_o    (ovf_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: levels follow the input after WINDOW straight disagreeing samples
  bit [WIDTH-1:0] h1, h2;
  bit [WIDTH-1:0] m_btn, m_rise, m_fall, m_pend, m_dir;
  int             m_run[WIDTH];
  bit             m_valid, m_rise_evt, m_ovf;
  int             m_chan;

  always @(posedge clk) begin : model
    bit [WIDTH-1:0] flip;
    bit             load;
    int             pick;
    logic [W-1:0]   e;
    if (!rst_n) begin
      h1 = '0; h2 = '0; m_btn = '0; m_rise = '0; m_fall = '0;
      m_pend = '0; m_dir = '0; m_valid = 0; m_rise_evt = 0; m_ovf = 0; m_chan = 0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      if (m_valid && evt_ready) begin
        e = {m_chan[CW-1:0], m_rise_evt};
        exp_q.push_back(e);
      end
      flip = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (h2[i] != m_btn[i]) begin
          m_run[i]++;
          if (m_run[i] == WINDOW) begin
            flip[i]  = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      load = !m_valid || evt_ready;
      pick = -1;
      for (int i = 0; i < WIDTH; i++) if (m_pend[i] && pick < 0) pick = i;
      if (load) begin
        if (pick >= 0) begin
          m_valid      = 1;
          m_chan       = pick;
          m_rise_evt   = m_dir[pick];
          m_pend[pick] = 1'b0;
        end else begin
          m_valid = 0;
        end
      end
      m_rise = flip & ~m_btn;
      m_fall = flip & m_btn;
      m_btn  = m_btn ^ flip;
      for (int i = 0; i < WIDTH; i++) begin
        if (flip[i]) begin
          if (m_pend[i]) m_ovf = 1;
          m_pend[i] = 1'b1;
          m_dir[i]  = m_btn[i];
        end
      end
      h2 = h1;
      h1 = btn_i;
    end
  end

  // monitor / scoreboard
  bit            hs_pend = 0;
  logic [W-1:0]  hs_evt;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (hs_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_extra: got %0h expected none at %0t", hs_evt, $time);
      end else begin
        e = exp_q.pop_front();
        check("evt_accept", 32'(hs_evt), 32'(e));
      end
    end
    hs_pend = (evt_valid === 1'b1) && (evt_ready === 1'b1) && (rst_n === 1'b1);
    hs_evt  = {evt_chan, evt_rise};
    check("btn_o", 32'(btn_o), 32'(m_btn));
    check("rise_o", 32'(rise_o), 32'(m_rise));
    check("fall_o", 32'(fall_o), 32'(m_fall));
    check("ovf_o", 32'(ovf_o), 32'(m_ovf));
    check("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      check("evt_chan", 32'(evt_chan), 32'(m_chan));
      check("evt_rise", 32'(evt_rise), 32'(m_rise_evt));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_run(input int ch, input int run, output bit ok);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (m_run[ch] == run && h2[ch] != m_btn[ch]) ok = 1;
      else tick();
    end
  endtask

  initial begin
    int lat;
    bit ok;
    rst_n     = 1'b0;
    btn_i     = '0;
    evt_ready = 1'b1;
    hold(2);
    check("reset_btn", 32'(btn_o), 0);
    check("reset_valid", 32'(evt_valid), 0);
    check("reset_ovf", 32'(ovf_o), 0);
    rst_n = 1'b1;
    hold(2);

    // clean press on ch1
    btn_i[1] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      tick();
      if (btn_o[1] === 1'b1) lat = k;
    end
    check("press_latency", 32'(lat), 10);
    check("press_rise", 32'(rise_o[1]), 1);
    tick();
    check("press_evt", 32'({evt_valid, evt_chan, evt_rise}), 32'({1'b1, 2'd1, 1'b1}));
    hold(4);

    // glitch shorter than the window on ch0
    btn_i[0] = 1'b1;
    hold(7);
    btn_i[0] = 1'b0;
    hold(14);
    check("glitch_btn", 32'(btn_o[0]), 0);

    // simultaneous presses on ch3 and ch0
    btn_i[3] = 1'b1;
    btn_i[0] = 1'b1;
    hold(14);
    check("simul_ovf", 32'(ovf_o), 0);
    btn_i = '0;
    hold(16);

    // ch2 transfer coinciding with a new ch2 edge
    evt_ready = 1'b0;
    btn_i[0]  = 1'b1;
    btn_i[2]  = 1'b1;
    hold(14);
    btn_i[2] = 1'b0;
    wait_run(2, WINDOW - 1, ok);
    check("same_cycle_found", 32'(ok), 1);
    evt_ready = 1'b1;
    hold(6);
    check("same_cycle_ovf", 32'(ovf_o), 0);
    btn_i[0] = 1'b0;
    hold(14);

    // backpressure: ch2 press and release while ch2 still pending
    evt_ready = 1'b0;
    btn_i[0]  = 1'b1;
    hold(3);
    btn_i[2] = 1'b1;
    hold(14);
    btn_i[2] = 1'b0;
    hold(14);
    check("bp_ovf", 32'(ovf_o), 1);
    check("bp_hold", 32'({evt_valid, evt_chan, evt_rise}), 32'({1'b1, 2'd0, 1'b1}));
    evt_ready = 1'b1;
    tick();
    check("bp_release_evt", 32'({evt_valid, evt_chan, evt_rise}), 32'({1'b1, 2'd2, 1'b0}));
    hold(4);

    // reset while ch1 is mid-count and an event is held
    evt_ready = 1'b0;
    btn_i[0]  = 1'b0;
    hold(14);
    btn_i[1] = 1'b1;
    wait_run(1, 5, ok);
    check("midcount_found", 32'(ok), 1);
    check("midcount_valid", 32'(evt_valid), 1);
    rst_n = 1'b0;
    tick();
    check("midreset_out", 32'({btn_o, rise_o, fall_o, evt_valid, ovf_o}), 0);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    hold(14);

    // random presses and random backpressure
    for (int n = 0; n < 60; n++) begin
      btn_i = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      repeat ($urandom_range(1, 16)) begin
        evt_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    evt_ready = 1'b1;
    hold(40);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Input-side counterpart to the board's LED/OBUF output path: takes WIDTH raw pushbutton/switch levels from the input pads, synchronizes and debounces each one, and reports clean levels, single-cycle edge strobes and a queued event stream. Sits directly behind the pad input buffers in board test designs and feeds the design's control logic through a valid/ready event port.

## Interface
- WIDTH, 4: number of input channels; legal range 2..16.
- LOG2DELAY, 16: debounce window is 2^LOG2DELAY consecutive cycles; legal range 1..24.
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- btn_i  in  WIDTH  raw pad levels, asynchronous to clk.
- btn_o  out  WIDTH  debounced levels; reset 0.
- rise_o  out  WIDTH  one-cycle strobe when btn_o[i] goes 0->1; reset 0.
- fall_o  out  WIDTH  one-cycle strobe when btn_o[i] goes 1->0; reset 0.
- evt_valid  out  1  event register holds an event; reset 0.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready.
- evt_chan  out  $clog2(WIDTH)  channel index of the event; reset 0.
- evt_rise  out  1  1 = press (0->1), 0 = release; reset 0.
- ovf_o  out  1  sticky: a pending event was overwritten; reset 0; cleared only by reset.

## Operation
- Per channel: 2-flop synchronizer (reset 0) -> sync[i]; stable-state register btn_o[i]; counter cnt[i] of LOG2DELAY bits (reset 0).
- Each cycle: if sync[i]==btn_o[i], cnt[i]<=0. Otherwise, if cnt[i]==2^LOG2DELAY-1, then btn_o[i]<=sync[i] and cnt[i]<=0; else cnt[i]<=cnt[i]+1.
- A glitch shorter than 2^LOG2DELAY cycles (after sync) resets the count and never changes btn_o.
- rise_o[i]/fall_o[i] are registered and high in exactly the cycle btn_o[i] shows its new value.
- Pending bits: pend[i] and dir[i]. On an edge of channel i, pend[i]<=1, dir[i]<=new level. If pend[i] was already 1 and is not being transferred this cycle, ovf_o<=1 and dir is replaced by the latest level.
- Event register loads when !evt_valid || evt_ready: selects the lowest-index i with pend[i]=1, sets evt_chan=i, evt_rise=dir[i], evt_valid=1, clears pend[i]. If no pend bit is set, evt_valid<=0.
- Simultaneous: a new edge on channel i in the cycle pend[i] is transferred sets pend[i] again (set wins); this is not an overflow.
- Handshake: while evt_valid && !evt_ready, evt_chan/evt_rise stay stable.
- Reset mid-operation: all synchronizers, counters, pend/dir, outputs and ovf_o go to 0 on the next edge with rst_n=0; in-flight events are dropped.

## Timing
- Pad change to btn_o: 2 synchronizer cycles + 2^LOG2DELAY cycles, for an input held stable throughout.
- btn_o change to evt_valid (register empty): 1 cycle.
- Back-to-back acceptance with evt_ready held high: one event per cycle.
- No combinational path from btn_i or evt_ready to any output.

## Structure
- Package debounce_pkg: constants MIN_WIDTH=2 and MAX_WIDTH=16, and the function chan_bits(width) used for the evt_chan width.
- Sub-module debounce_chan: synchronizer, counter, stable register and edge strobes for one channel, parameterized by LOG2DELAY and generated WIDTH times. The pending logic, priority select and event register stay in the top module.

## Test plan
- Clean press, LOG2DELAY=3, ch1 0->1 held: btn_o[1] rises 10 cycles after btn_i; rise_o[1] pulses once; next cycle evt_valid=1, evt_chan=1, evt_rise=1.
- Glitch: ch0 high for 7 cycles, then low. btn_o, rise_o, evt_valid stay 0; the counter returns to 0.
- Simultaneous presses on ch3 and ch0 in the same cycle, evt_ready=1: events ch0 then ch3 on consecutive cycles; ovf_o=0.
- Backpressure: evt_ready=0; ch2 press then release accepted by the debouncer while ch2 is still pending. ovf_o=1. Holding event stays stable; after ready, the ch2 event shows evt_rise=0.
- Reset mid-count: rst_n=0 for 1 cycle while cnt[1]=5 and evt_valid=1. All outputs are 0 the next cycle, and the count restarts from 0.
- Same-cycle transfer and edge on ch2 with evt_ready=1: pend[2] is re-set, a second ch2 event follows, and ovf_o stays 0.
